word_demux_dispatch: RTL and testbench
======================================

// Module: word_demux_dispatch
// PURPOSE
//  Upstream feeder for the decryption stages (caesar / scytale / zigzag).
//  - Accepts one packed multi-byte word plus a channel select.
//  - Splits the word into bytes, MSB first.
//  - Presents each byte on a shared data bus with a one-hot per-channel valid.
//  - Stalls while the selected decryption stage raises busy.
// PARAMETERS
//  DATA_W     8   byte width; matches decryption data_i
//  NUM_BYTES  4   bytes per input word
//  NUM_CH     3   number of downstream decryption channels
//  SEL_W      2   select width; must satisfy 2**SEL_W >= NUM_CH
// PORTS
//  clk       in   1                 single system clock
//  rst       in   1                 reset
//  data_i    in   DATA_W*NUM_BYTES  packed word; byte 0 = MSB slice
//  valid_i   in   1                 data_i/select_i valid; accepted only when ready_o=1
//  select_i  in   SEL_W             target channel 0..NUM_CH-1
//  ready_o   out  1                 block can accept a word this cycle
//  busy_i    in   NUM_CH            per-channel busy from decryption stages
//  data_o    out  DATA_W            shared byte bus to all channels
//  valid_o   out  NUM_CH            one-hot byte valid; bit k feeds channel k valid_i
//  drop_cnt_o out 8                 count of dropped words (see CONFIGURATION)
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-high.
//  - Reset values: data_o=0, valid_o=0, drop_cnt_o=0, state=IDLE, byte index=0.
//    ready_o=1 after reset (it is combinational from state).
//  - States: IDLE and SEND.
//  - Handshake: a word is accepted at a rising edge where valid_i && ready_o.
//    - On acceptance, data_i and select_i are latched and the byte index is cleared.
//    - valid_i while ready_o=0 is ignored; upstream holds the word until it is accepted.
//  - IDLE:
//    - ready_o=1.
//    - Accepted word with select_i < NUM_CH -> SEND.
//    - Accepted word with select_i >= NUM_CH -> dropped, stay in IDLE, no valid_o pulse.
//  - SEND, evaluated at each edge:
//    - If busy_i[sel]=0: data_o <= byte[idx], valid_o <= (1<<sel), idx++.
//    - If busy_i[sel]=1: valid_o <= 0 and data_o is held; idx is unchanged.
//  - Last byte (idx=NUM_BYTES-1, not busy): ready_o=1 in that same cycle.
//    - If a new word is accepted at that edge, stay in SEND with idx=0 (back-to-back, no bubble).
//    - Otherwise -> IDLE.
//  - ready_o = IDLE || (SEND && idx==NUM_BYTES-1 && !busy_i[sel]). It is the only combinational output.
//  - Latency: word accepted at edge N -> byte 0 visible after edge N+1.
//    With no busy, NUM_BYTES bytes appear on consecutive cycles.
//  - valid_o is a single-cycle pulse per byte and is never high on more than one channel.
//  - select_i and data_i changes during SEND have no effect; the latched copies are used.
//  - busy_i on non-selected channels is ignored.
//  - rst asserted mid-word: the word is abandoned, outputs clear immediately,
//    and no partial bytes are emitted after release.
// CONFIGURATION
//  - DROP_COUNT_EN defined:
//    - drop_cnt_o increments on each word dropped for select_i >= NUM_CH.
//    - Saturates at 255; cleared only by rst.
//  - DROP_COUNT_EN undefined:
//    - drop_cnt_o is tied to 0 and no counter logic is built.
//    - Dropping behaviour is otherwise identical.
// TESTING
//  1. Reset then word 0x01020314, sel=0, busy=0 -> valid_o=3'b001 for 4 cycles,
//     data_o 0x01,0x02,0x03,0x14, starting 1 cycle after acceptance.
//  2. Word 0xAABBCCDD, sel=2; busy_i[2]=1 for 2 cycles after byte 0xAA
//     -> gap of 2 cycles, then 0xBB,0xCC,0xDD; busy_i[0] toggling is ignored.
//  3. Two words back-to-back with valid_i held, sel=1 then sel=0
//     -> 8 consecutive byte pulses, valid_o switches 010 -> 001 with no idle cycle.
//  4. sel=3 with valid_i=1 for 3 cycles -> no valid_o pulses;
//     drop_cnt_o=3 with DROP_COUNT_EN, 0 without.
//  5. rst pulsed after byte 2 of a word -> valid_o=0 and data_o=0 immediately,
//     ready_o=1; next word starts at its own byte 0.
//  6. valid_i toggled while ready_o=0 (mid-word) -> ignored;
//     the current word completes unchanged.

Source files
------------

// File: rtl/word_demux_dispatch.sv
// Word-to-byte demux feeding the caesar/scytale/zigzag decryption channels.
// Optional feature: define DROP_COUNT_EN to build the dropped-word counter.
module word_demux_dispatch #(
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = 4,
  parameter int NUM_CH    = 3,
  parameter int SEL_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W*NUM_BYTES-1:0] data_i,
  input  logic                        valid_i,
  input  logic [SEL_W-1:0]            select_i,
  output logic                        ready_o,
  input  logic [NUM_CH-1:0]           busy_i,
  output logic [DATA_W-1:0]           data_o,
  output logic [NUM_CH-1:0]           valid_o,
  output logic [7:0]                  drop_cnt_o
);

  localparam int WORD_W = DATA_W * NUM_BYTES;
  localparam int IDX_W  =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]   valid_q, valid_d;

  logic [NUM_CH-1:0]   sel_oh;
  logic [DATA_W-1:0]   cur_byte;
  logic                busy_sel;
  logic                last;
  logic                accept;
  logic                sel_ok;

  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_oh[k] = (sel_q == SEL_W'(k));
    end
  end

  // Byte 0 is the most significant slice of the word.
  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_byte = word_q[WORD_W-1-k*DATA_W -: DATA_W];
      end
    end
  end

  assign busy_sel = |(busy_i & sel_oh);
  assign last     = (idx_q == IDX_W'(NUM_BYTES - 1));
  assign sel_ok   =
    ({1'b0, select_i} < (SEL_W + 1)'(NUM_CH));

  assign ready_o = (state_q == IDLE) ||
                   ((state_q == SEND) && last && !busy_sel);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = '0;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SEND: begin
        if (!busy_sel) begin
          data_d  = cur_byte;
          valid_d = sel_oh;
          idx_d   = idx_q + IDX_W'(1);
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new word may land on the last-byte edge, giving no bubble.
    if (accept) begin
      word_d = data_i;
      sel_d  = select_i;
      idx_d  = '0;
      state_d = sel_ok ? SEND : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef DROP_COUNT_EN
  logic [7:0] drop_q;
  logic       drop;

  assign drop = accept && !sel_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_word_demux_dispatch.sv
// Directed bench for word_demux_dispatch.
// Expected drop count follows DROP_COUNT_EN.
module tb_word_demux_dispatch;

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic        valid_i;
  logic [1:0]  select_i;
  logic        ready_o;
  logic [2:0]  busy_i;
  logic [7:0]  data_o;
  logic [2:0]  valid_o;
  logic [7:0]  drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  word_demux_dispatch dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .select_i   (select_i),
    .ready_o    (ready_o),
    .busy_i     (busy_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag,
                          input logic [2:0] vexp,
                          input logic [7:0] dexp);
    chk({tag, "_v"}, {29'd0, valid_o}, {29'd0, vexp});
    chk({tag, "_d"}, {24'd0, data_o}, {24'd0, dexp});
  endtask

  logic [7:0] exp_drop;

  initial begin
`ifdef DROP_COUNT_EN
    exp_drop = 8'd3;
`else
    exp_drop = 8'd0;
`endif
    rst      = 1'b1;
    data_i   = '0;
    valid_i  = 1'b0;
    select_i = '0;
    busy_i   = '0;
    repeat (2) tick();
    chk_byte("rst", 3'b000, 8'h00);
    chk("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    chk("rst_rdy", {31'd0, ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: plain word on channel 0
    data_i = 32'h01020314; select_i = 2'd0; valid_i = 1'b1;
    chk("t1_rdy", {31'd0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    chk_byte("t1_lat", 3'b000, 8'h00);
    chk("t1_busyrdy", {31'd0, ready_o}, 32'd0);
    tick(); chk_byte("t1_b0", 3'b001, 8'h01);
    tick(); chk_byte("t1_b1", 3'b001, 8'h02);
    tick(); chk_byte("t1_b2", 3'b001, 8'h03);
    chk("t1_lastrdy", {31'd0, ready_o}, 32'd1);
    tick(); chk_byte("t1_b3", 3'b001, 8'h14);
    tick(); chk_byte("t1_end", 3'b000, 8'h14);

    // 2: busy stalls on channel 2; busy on channel 0 ignored
    data_i = 32'hAABBCCDD; select_i = 2'd2; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick(); chk_byte("t2_b0", 3'b100, 8'hAA);
    busy_i = 3'b101;
    chk("t2_stallrdy", {31'd0, ready_o}, 32'd0);
    tick(); chk_byte("t2_g0", 3'b000, 8'hAA);
    busy_i = 3'b100;
    tick(); chk_byte("t2_g1", 3'b000, 8'hAA);
    busy_i = 3'b001;
    tick(); chk_byte("t2_b1", 3'b100, 8'hBB);
    busy_i = 3'b000;
    tick(); chk_byte("t2_b2", 3'b100, 8'hCC);
    busy_i = 3'b001;
    tick(); chk_byte("t2_b3", 3'b100, 8'hDD);
    busy_i = 3'b000;
    tick(); chk_byte("t2_end", 3'b000, 8'hDD);

    // 3: back-to-back, valid held, sel 1 then sel 0
    data_i = 32'h11223344; select_i = 2'd1; valid_i = 1'b1;
    tick();
    data_i = 32'h55667788; select_i = 2'd0;
    tick(); chk_byte("t3_a0", 3'b010, 8'h11);
    tick(); chk_byte("t3_a1", 3'b010, 8'h22);
    tick(); chk_byte("t3_a2", 3'b010, 8'h33);
    chk("t3_rdy", {31'd0, ready_o}, 32'd1);
    tick(); chk_byte("t3_a3", 3'b010, 8'h44);
    valid_i = 1'b0;
    tick(); chk_byte("t3_b0", 3'b001, 8'h55);
    tick(); chk_byte("t3_b1", 3'b001, 8'h66);
    tick(); chk_byte("t3_b2", 3'b001, 8'h77);
    tick(); chk_byte("t3_b3", 3'b001, 8'h88);
    tick(); chk_byte("t3_end", 3'b000, 8'h88);

    // 4: out-of-range select dropped three times
    data_i = 32'hCAFEF00D; select_i = 2'd3; valid_i = 1'b1;
    tick(); chk_byte("t4_c0", 3'b000, 8'h88);
    tick(); chk_byte("t4_c1", 3'b000, 8'h88);
    tick(); chk_byte("t4_c2", 3'b000, 8'h88);
    valid_i = 1'b0;
    chk("t4_rdy", {31'd0, ready_o}, 32'd1);
    tick(); chk_byte("t4_c3", 3'b000, 8'h88);
    chk("t4_drop", {24'd0, drop_cnt_o}, {24'd0, exp_drop});

    // 5: reset mid-word
    data_i = 32'hDEADBEEF; select_i = 2'd1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick(); chk_byte("t5_b0", 3'b010, 8'hDE);
    tick(); chk_byte("t5_b1", 3'b010, 8'hAD);
    rst = 1'b1;
    #1;
    chk_byte("t5_rst", 3'b000, 8'h00);
    chk("t5_rdy", {31'd0, ready_o}, 32'd1);
    chk("t5_drop", {24'd0, drop_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(); chk_byte("t5_idle", 3'b000, 8'h00);
    tick(); chk_byte("t5_idle2", 3'b000, 8'h00);
    data_i = 32'h0A0B0C0D; select_i = 2'd2; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick(); chk_byte("t5_n0", 3'b100, 8'h0A);
    tick(); chk_byte("t5_n1", 3'b100, 8'h0B);
    tick(); chk_byte("t5_n2", 3'b100, 8'h0C);
    tick(); chk_byte("t5_n3", 3'b100, 8'h0D);

    // 6: valid_i toggling mid-word is ignored
    data_i = 32'h10203040; select_i = 2'd0; valid_i = 1'b1;
    tick();
    data_i = 32'hFFFFFFFF; select_i = 2'd1;
    tick(); chk_byte("t6_b0", 3'b001, 8'h10);
    valid_i = 1'b0;
    tick(); chk_byte("t6_b1", 3'b001, 8'h20);
    valid_i = 1'b1;
    tick(); chk_byte("t6_b2", 3'b001, 8'h30);
    valid_i = 1'b0;
    tick(); chk_byte("t6_b3", 3'b001, 8'h40);
    tick(); chk_byte("t6_end", 3'b000, 8'h40);
    tick(); chk_byte("t6_end2", 3'b000, 8'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
